// File: rtl/nios_practica_rst_seq.sv
// rtl/nios_practica_rst_seq.sv - PLL-lock driven system reset sequencer
//
// Holds the Nios core and its peripherals in reset until the PLL lock has been
// stable for LOCK_STABLE_CYCLES cycles and a further HOLD_CYCLES hold-off has
// elapsed. The system reset asserts asynchronously through rst and deasserts
// only on a clk edge.
//
// Ports:
//   clk            PLL output clock (outclk_0 domain)
//   rst            asynchronous active-high reset
//   pll_locked     PLL lock indicator, asynchronous to clk
//   sw_reset_req   synchronous software reset request (level or pulse)
//   rst_out        system reset, active-high, registered
//   rst_n_out      complement of rst_out, from its own flop
//   locked_sync    pll_locked after the two-flop synchronizer
//   lock_loss_cnt  saturating count of lock losses seen while running
//
// Build option: RST_SEQ_LOSS_CNT_EN implements lock_loss_cnt; without it the
// output is tied to 8'h00 and no counter logic exists.

module nios_practica_rst_seq #(
    parameter int LOCK_STABLE_CYCLES = 8,
    parameter int HOLD_CYCLES        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       sw_reset_req,
    output logic       rst_out,
    output logic       rst_n_out,
    output logic       locked_sync,
    output logic [7:0] lock_loss_cnt
);

    localparam int CNT_MAX = (LOCK_STABLE_CYCLES > HOLD_CYCLES) ? LOCK_STABLE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RESET     = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             sync_meta;
    logic             rst_d;

    // Two-flop synchronizer for the asynchronous lock indicator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta   <= 1'b0;
            locked_sync <= 1'b0;
        end else begin
            sync_meta   <= pll_locked;
            locked_sync <= sync_meta;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RESET;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic. Lock loss always wins over a software request.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            ST_RESET: begin
                next_state = ST_WAIT_LOCK;
                cnt_next   = '0;
            end
            ST_WAIT_LOCK: begin
                if (!locked_sync) begin
                    cnt_next = '0;
                end else if (cnt == LOCK_LAST) begin
                    next_state = ST_HOLD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!locked_sync) begin
                    next_state = ST_WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt == HOLD_LAST) begin
                    next_state = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!locked_sync) begin
                    next_state = ST_WAIT_LOCK;
                    cnt_next   = '0;
                end else if (sw_reset_req) begin
                    next_state = ST_HOLD;
                    cnt_next   = '0;
                end
            end
            default: begin
                next_state = ST_RESET;
                cnt_next   = '0;
            end
        endcase
    end

    // Output decode works on next_state so the registered reset reasserts on
    // the same edge that leaves RUN rather than one cycle later.
    always_comb begin
        rst_d = (next_state != ST_RUN);
    end

    // Reset outputs come straight from flops so they cannot glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_out   <= 1'b1;
            rst_n_out <= 1'b0;
        end else begin
            rst_out   <= rst_d;
            rst_n_out <= ~rst_d;
        end
    end

`ifdef RST_SEQ_LOSS_CNT_EN
    logic [7:0] loss_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loss_q <= 8'h00;
        end else if (state == ST_RUN && !locked_sync && loss_q != 8'hFF) begin
            loss_q <= loss_q + 8'h01;
        end
    end

    assign lock_loss_cnt = loss_q;
`else
    assign lock_loss_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_nios_practica_rst_seq.sv
// tb/tb_nios_practica_rst_seq.sv - self-checking bench for nios_practica_rst_seq

module tb_nios_practica_rst_seq;

    localparam int L = 8;
    localparam int H = 4;

`ifdef RST_SEQ_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       pll_locked;
    logic       sw_reset_req;
    logic       rst_out;
    logic       rst_n_out;
    logic       locked_sync;
    logic [7:0] lock_loss_cnt;

    int checks = 0;
    int fails  = 0;

    nios_practica_rst_seq #(
        .LOCK_STABLE_CYCLES(L),
        .HOLD_CYCLES(H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pll_locked(pll_locked),
        .sw_reset_req(sw_reset_req),
        .rst_out(rst_out),
        .rst_n_out(rst_n_out),
        .locked_sync(locked_sync),
        .lock_loss_cnt(lock_loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: count consecutive synced-lock samples up to L, then
    // count down an H-edge hold-off; the system runs once the hold-off is spent.
    bit m_s1, m_s2, m_seen;
    bit m_started, m_running, m_holding;
    int m_stable, m_hold_left, m_loss;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_started = 0; m_running = 0; m_holding = 0;
            m_stable = 0; m_hold_left = 0; m_loss = 0;
        end else begin
            m_seen = m_s2;
            m_s2   = m_s1;
            m_s1   = pll_locked;
            if (!m_started) begin
                m_started = 1;
                m_stable  = 0;
            end else if (m_running) begin
                if (!m_seen) begin
                    m_running = 0;
                    m_stable  = 0;
                    if (LOSS_EN && m_loss < 255) m_loss++;
                end else if (sw_reset_req) begin
                    m_running   = 0;
                    m_holding   = 1;
                    m_hold_left = H;
                end
            end else if (m_holding) begin
                if (!m_seen) begin
                    m_holding = 0;
                    m_stable  = 0;
                end else begin
                    m_hold_left--;
                    if (m_hold_left == 0) begin
                        m_holding = 0;
                        m_running = 1;
                    end
                end
            end else begin
                if (m_seen) begin
                    m_stable++;
                    if (m_stable == L) begin
                        m_holding   = 1;
                        m_hold_left = H;
                    end
                end else begin
                    m_stable = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_rst_out", 32'(rst_out), 32'(!m_running));
        chk("model_rst_n_out", 32'(rst_n_out), 32'(m_running));
        chk("model_locked_sync", 32'(locked_sync), 32'(m_s2));
        chk("model_lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_run(input int budget);
        int n = 0;
        while (rst_out !== 1'b0 && n < budget) begin
            tick(1);
            n++;
        end
        chk("wait_run_timeout", 32'(rst_out), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        pll_locked = 1'b1;
        sw_reset_req = 1'b0;
        #1;
        chk("reset_rst_out", 32'(rst_out), 32'd1);
        chk("reset_rst_n_out", 32'(rst_n_out), 32'd0);
        chk("reset_locked_sync", 32'(locked_sync), 32'd0);
        chk("reset_loss_cnt", 32'(lock_loss_cnt), 32'd0);

        // Power-up with lock held throughout.
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("pu_sync_edge1", 32'(locked_sync), 32'd0);
        tick(1);
        chk("pu_sync_edge2", 32'(locked_sync), 32'd1);
        tick(11);
        chk("pu_edge13_rst", 32'(rst_out), 32'd1);
        tick(1);
        chk("pu_edge14_rst", 32'(rst_out), 32'd0);
        chk("pu_edge14_rst_n", 32'(rst_n_out), 32'd1);

        // Lock glitch before qualification.
        rst = 1'b1;
        pll_locked = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(2);
        pll_locked = 1'b1;
        tick(5);
        pll_locked = 1'b0;
        tick(2);
        pll_locked = 1'b1;
        tick(13);
        chk("glitch_edge13_rst", 32'(rst_out), 32'd1);
        tick(1);
        chk("glitch_edge14_rst", 32'(rst_out), 32'd0);

        // Lock loss while running.
        pll_locked = 1'b0;
        tick(2);
        chk("loss_edge2_rst", 32'(rst_out), 32'd0);
        tick(1);
        chk("loss_edge3_rst", 32'(rst_out), 32'd1);
        chk("loss_cnt_1", 32'(lock_loss_cnt), LOSS_EN ? 32'd1 : 32'd0);
        pll_locked = 1'b1;
        tick(13);
        chk("relock_edge13_rst", 32'(rst_out), 32'd1);
        tick(1);
        chk("relock_edge14_rst", 32'(rst_out), 32'd0);

        // One-cycle software request, then a request during HOLD.
        sw_reset_req = 1'b1;
        tick(1);
        sw_reset_req = 1'b0;
        chk("sw_edge1_rst", 32'(rst_out), 32'd1);
        tick(1);
        chk("sw_edge2_rst", 32'(rst_out), 32'd1);
        sw_reset_req = 1'b1;
        tick(1);
        sw_reset_req = 1'b0;
        chk("sw_edge3_rst", 32'(rst_out), 32'd1);
        tick(1);
        chk("sw_edge4_rst", 32'(rst_out), 32'd1);
        tick(1);
        chk("sw_edge5_rst", 32'(rst_out), 32'd0);

        // Held request cycles HOLD/RUN; the model checks every cycle.
        sw_reset_req = 1'b1;
        tick(12);
        sw_reset_req = 1'b0;
        wait_run(20);

        // Lock loss and software request sampled on the same edge.
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(1);
        sw_reset_req = 1'b1;
        tick(1);
        sw_reset_req = 1'b0;
        chk("both_edge3_rst", 32'(rst_out), 32'd1);
        chk("both_loss_cnt", 32'(lock_loss_cnt), LOSS_EN ? 32'd2 : 32'd0);
        tick(4);
        chk("both_edge7_rst", 32'(rst_out), 32'd1);
        tick(7);
        chk("both_edge14_rst", 32'(rst_out), 32'd1);
        tick(1);
        chk("both_edge15_rst", 32'(rst_out), 32'd0);

        // Saturation of the loss counter.
        if (LOSS_EN) begin
            repeat (256) begin
                pll_locked = 1'b0;
                tick(3);
                pll_locked = 1'b1;
                wait_run(40);
            end
            chk("loss_saturated", 32'(lock_loss_cnt), 32'hFF);
        end

        // Asynchronous reset in the middle of a sequence.
        pll_locked = 1'b0;
        tick(4);
        pll_locked = 1'b1;
        tick(6);
        rst = 1'b1;
        #1;
        chk("async_rst_out", 32'(rst_out), 32'd1);
        chk("async_rst_n_out", 32'(rst_n_out), 32'd0);
        chk("async_locked_sync", 32'(locked_sync), 32'd0);
        chk("async_loss_cnt", 32'(lock_loss_cnt), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(14);
        chk("restart_edge14_rst", 32'(rst_out), 32'd0);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
